sem_arbiter: RTL

//  Shares one semaphore channel between N_REQ producer CPU cores. Each core presents
//  a word on a valid/ack handshake. A round-robin arbiter picks one core at a time and

---
 rtl/sem_arbiter_pkg.sv | 25 ++
 rtl/sem_arbiter_if.sv | 35 +++
 rtl/sem_arbiter_fifo.sv | 72 +++++++
 rtl/sem_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sem_arbiter_pkg.sv
// Shared types and helpers for the semaphore arbiter slice.
// DefaultDataWidth is the default semaphore word width.
package sem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT     = 2'd1,
      WAIT_DROP = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   localparam int DefaultDataWidth = 1;

endpackage

// File: rtl/sem_arbiter_if.sv
// Producer-side request bundle and consumer-side FIFO read port of the semaphore arbiter.
// master = producers/consumer driving requests and reads, slave = the arbiter itself.
interface sem_arbiter_if
  import sem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DefaultDataWidth,
  parameter int N_REQ      = 4,
  parameter int DEPTH      = 8
);
  localparam int LevelWidth = clog2(DEPTH) + 1;

  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]       sem_data_out;
  logic                        sem_data_valid_out;
  logic                        sem_data_read;
  logic                        sem_data_empty;
  logic                        fifo_full;
  logic [LevelWidth-1:0]       fifo_level;
  logic [1:0]                  state;

  modport master (
    output req_data, req_valid, sem_data_read,
    input  req_ack, sem_data_out, sem_data_valid_out, sem_data_empty,
           fifo_full, fifo_level, state
  );

  modport slave (
    input  req_data, req_valid, sem_data_read,
    output req_ack, sem_data_out, sem_data_valid_out, sem_data_empty,
           fifo_full, fifo_level, state
  );

endinterface

// File: rtl/sem_arbiter_fifo.sv
// Show-ahead FIFO for the semaphore arbiter: head word is visible combinationally,
// zero when empty. Pointers wrap naturally because DEPTH is a power of two.
module sem_fifo
  import sem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DefaultDataWidth,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       pop_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [clog2(DEPTH):0]      level_o
);
  localparam int PtrWidth   = clog2(DEPTH);
  localparam int LevelWidth = PtrWidth + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrWidth-1:0]   rdPtr_q, rdPtr_d;
  logic [PtrWidth-1:0]   wrPtr_q, wrPtr_d;
  logic [LevelWidth-1:0] level_q, level_d;
  logic                  wrEn, rdEn;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LevelWidth'(DEPTH));
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem[rdPtr_q];

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign rdEn = pop_i && !empty_o;
  assign wrEn = push_i && (!full_o || rdEn);

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    level_d = level_q;
    if (rdEn) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (wrEn) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    case ({wrEn, rdEn})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      level_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sem_arbiter.sv
// Shares one semaphore FIFO between N_REQ producers via a grant/ack FSM.
// Define SEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sem_arbiter
  import sem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DefaultDataWidth,
  parameter int N_REQ      = 4,
  parameter int DEPTH      = 8
) (
  input logic          clk,
  input logic          rst,
  sem_arbiter_if.slave bus
);
  localparam int IdWidth    = clog2(N_REQ);
  localparam int LevelWidth = clog2(DEPTH) + 1;

  state_e                state_q, state_d;
  logic [IdWidth-1:0]    grantId_q, grantId_d;
  logic [IdWidth-1:0]    winnerId;
  logic                  winnerFound;
  logic                  pushEn;
  logic [N_REQ-1:0]      ackVec;
  logic [DATA_WIDTH-1:0] pushData;
  logic [DATA_WIDTH-1:0] headData;
  logic                  fifoEmpty, fifoFull;
  logic [LevelWidth-1:0] fifoLevel;
`ifndef SEM_ARB_FIXED_PRIO_EN
  logic [IdWidth-1:0]    rrPtr_q, rrPtr_d;
`endif

  // Scan requesters starting at the round-robin pointer (or index 0 in fixed mode).
  always_comb begin
    int idx;
    logic [IdWidth-1:0] cand;
    winnerId    = '0;
    winnerFound = 1'b0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef SEM_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(rrPtr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
`endif
      cand = IdWidth'(idx);
      if (!winnerFound && bus.req_valid[cand]) begin
        winnerId    = cand;
        winnerFound = 1'b1;
      end
    end
  end

  always_comb begin
    pushData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantId_q == IdWidth'(i)) begin
        pushData = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
`ifndef SEM_ARB_FIXED_PRIO_EN
    rrPtr_d   = rrPtr_q;
`endif
    pushEn    = 1'b0;
    ackVec    = '0;
    case (state_q)
      IDLE: begin
        if (!fifoFull && winnerFound) begin
          grantId_d = winnerId;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        // A producer that withdrew its word while granted gets neither ack nor push.
        if (bus.req_valid[grantId_q]) begin
          pushEn            = 1'b1;
          ackVec[grantId_q] = 1'b1;
`ifndef SEM_ARB_FIXED_PRIO_EN
          rrPtr_d = (grantId_q == IdWidth'(N_REQ - 1)) ? '0 : grantId_q + 1'b1;
`endif
          state_d = WAIT_DROP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_DROP: begin
        if (!bus.req_valid[grantId_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grantId_q <= '0;
`ifndef SEM_ARB_FIXED_PRIO_EN
      rrPtr_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
`ifndef SEM_ARB_FIXED_PRIO_EN
      rrPtr_q   <= rrPtr_d;
`endif
    end
  end

  sem_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushEn),
    .data_i  (pushData),
    .pop_i   (bus.sem_data_read),
    .data_o  (headData),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull),
    .level_o (fifoLevel)
  );

  assign bus.req_ack            = ackVec;
  assign bus.sem_data_out       = headData;
  assign bus.sem_data_valid_out = !fifoEmpty;
  assign bus.sem_data_empty     = fifoEmpty;
  assign bus.fifo_full          = fifoFull;
  assign bus.fifo_level         = fifoLevel;
  assign bus.state              = state_q;

endmodule
